// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller.
//   - state_e      : controller FSM states
//   - *_DEF        : default memory map parameters
//   - get_byte     : big-endian byte-lane select (lane 0 = bits [31:24])
//   - put_byte     : big-endian byte-lane insert
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned MEM_BYTES_DEF = 256;

    // Lane idx of a big-endian word: idx 0 is the most significant byte.
    function automatic logic [7:0] get_byte(logic [31:0] word, logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(logic [31:0] word, logic [1:0] idx,
                                             logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Byte-wide request/acknowledge bus between the access controller (master)
// and a byte memory responder (slave).
//   mem_addr  : byte offset into the memory
//   mem_wdata : byte write data
//   mem_we    : byte write strobe
//   mem_re    : byte read strobe
//   mem_rdata : byte read data, valid while mem_ack is high
//   mem_ack   : responder completes the current byte
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns a MEM-stage 32-bit word read/write into
// four sequential big-endian byte transfers on a byte-wide req/ack bus, holding
// ready low until the word completes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   MEM_w_en   : word write request
//   MEM_r_en   : word read request (write wins when both are high)
//   address    : CPU byte address, bits [1:0] ignored
//   data_in    : write data
//   data_out   : registered read data, updated only in a read's DONE cycle
//   ready      : 0 freezes the pipeline
//   err        : one-cycle pulse when an access is aborted (range or timeout)
//   bus        : byte bus master side
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MEM_w_en,
    input  logic                      MEM_r_en,
    input  logic [31:0]               address,
    input  logic [31:0]               data_in,
    output logic [31:0]               data_out,
    output logic                      ready,
    output logic                      err,
    mem_access_ctrl_if.master         bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic              is_wr_q;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rasm_q;
    logic [1:0]        idx_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       data_out_q;
    logic              err_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic [31:0]       aligned;
    logic              out_of_range;

    always_comb begin
        aligned      = address & 32'hFFFF_FFFC;
        out_of_range = (aligned < BASE_ADDR) || (aligned > BASE_ADDR + MEM_BYTES - 4);
    end

    // Combinational so the pipeline freezes in the very cycle a request appears.
    assign ready = ~(MEM_w_en | MEM_r_en) | (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rasm_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (MEM_w_en | MEM_r_en) begin
                        is_wr_q <= MEM_w_en;
                        wdata_q <= data_in;
                        addr_q  <= aligned[31:2];
                        idx_q   <= 2'd0;
                        cnt_q   <= '0;
                        if (out_of_range) begin
                            state_q <= StDone;
                            err_q   <= 1'b1;
                            if (!MEM_w_en) begin
                                data_out_q <= '0;
                            end
                        end else begin
                            state_q     <= StAccess;
                            mem_addr_q  <= ADDR_W'(aligned - BASE_ADDR);
                            mem_wdata_q <= get_byte(data_in, 2'd0);
                            mem_we_q    <= MEM_w_en;
                            mem_re_q    <= ~MEM_w_en;
                        end
                    end
                end

                StAccess: begin
                    if (bus.mem_ack) begin
                        cnt_q <= '0;
                        if (!is_wr_q) begin
                            rasm_q <= put_byte(rasm_q, idx_q, bus.mem_rdata);
                        end
                        if (idx_q == 2'd3) begin
                            state_q  <= StDone;
                            mem_we_q <= 1'b0;
                            mem_re_q <= 1'b0;
                            // Last byte goes straight into data_out so the word is
                            // visible in the DONE cycle.
                            if (!is_wr_q) begin
                                data_out_q <= put_byte(rasm_q, idx_q, bus.mem_rdata);
                            end
                        end else begin
                            idx_q       <= idx_q + 2'd1;
                            mem_addr_q  <= ADDR_W'({addr_q, idx_q + 2'd1} - BASE_ADDR);
                            mem_wdata_q <= get_byte(wdata_q, idx_q + 2'd1);
                        end
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        // This wait cycle is the TIMEOUT-th without ack: abort.
                        cnt_q    <= cnt_q + 1'b1;
                        state_q  <= StDone;
                        err_q    <= 1'b1;
                        mem_we_q <= 1'b0;
                        mem_re_q <= 1'b0;
                        if (!is_wr_q) begin
                            data_out_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign err           = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

endmodule
